// File: rtl/e_inst_sched_pkg.sv
// Shared types for the EInst scheduler and its chunk-range helper.
// Shared by e_inst_sched and e_sched_outcnt.
package e_inst_sched_pkg;

    localparam int EColW = 4;

    typedef enum logic [2:0] {
        EOpNop,
        EOpLoad,
        EOpMac,
        EOpAct,
        EOpStore
    } EOpCode;

    typedef struct packed {
        EOpCode             eOpCode;
        logic [EColW-1:0]   colBegin;
        logic [EColW-1:0]   colEnd;
        logic               mvsync;
        logic               eLast;
    } EInst;

    typedef enum logic [1:0] {
        ESIDLE,
        ESISSUE,
        ESDRAIN
    } ESchedState;

    // step is never 0 here; the sum is one bit wider so it cannot wrap
    function automatic logic [EColW-1:0] chunkEnd(
        input logic [EColW-1:0] ptr,
        input logic [EColW:0]   step,
        input logic [EColW-1:0] last
    );
        logic [EColW:0] sum;
        sum = {1'b0, ptr} + step - (EColW+1)'(1);
        return (sum > {1'b0, last}) ? last : sum[EColW-1:0];
    endfunction

endpackage

// File: rtl/e_sched_outcnt.sv
// Outstanding-EInst counter: issued but not yet finished chunks.
module e_sched_outcnt
    import e_inst_sched_pkg::*;
#(
    parameter int MaxOut = 4,
    localparam int CntW = $clog2(MaxOut + 1)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            inc,
    input  logic            dec,
    output logic [CntW-1:0] cnt,
    output logic            full,
    output logic            zero,
    output logic            underflow
);

    assign full      = (cnt == CntW'(MaxOut));
    assign zero      = (cnt == '0);
    assign underflow = dec & ~inc & zero;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else begin
            unique case (1'b1)
                inc & ~dec:         cnt <= cnt + CntW'(1);
                dec & ~inc & ~zero: cnt <= cnt - CntW'(1);
                default:            ;
            endcase
        end
    end

endmodule

// File: rtl/e_inst_sched.sv
// Splits a column-range macro command into EInst chunks with an outstanding limit.
// Define ESCHED_PERF_EN to build the busy/stall cycle counters.
module e_inst_sched
    import e_inst_sched_pkg::*;
#(
    parameter int VColLoop = 16,
    parameter int MaxOut = 4,
    localparam int ColW = $clog2(VColLoop),
    localparam int CntW = $clog2(MaxOut + 1)
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    cmdValid,
    output logic                    cmdReady,
    input  EOpCode                  cmdOpCode,
    input  logic [ColW-1:0]         cmdColBegin,
    input  logic [ColW-1:0]         cmdColEnd,
    input  logic [ColW-1:0]         cmdColStep,
    input  logic                    cmdSync,
    output logic                    eValid,
    input  logic                    eReady,
    output logic [$bits(EInst)-1:0] eInst,
    input  logic                    eFinish,
    output logic                    busy,
    output logic                    done,
    output logic                    errCmd,
    output logic                    errUnderflow,
    output logic [31:0]             perfBusyCyc,
    output logic [31:0]             perfStallCyc
);

    ESchedState      state;
    EOpCode          opQ;
    logic [ColW-1:0] ptr;
    logic [ColW-1:0] endQ;
    logic            mvsyncQ;
    logic            lastQ;
    logic [ColW-1:0] colBeginQ;
    logic [ColW-1:0] colEndQ;
    logic [ColW:0]   stepQ;
    logic            syncQ;

    logic [CntW-1:0] outCnt;
    logic            outFull;
    logic            outZero;
    logic            underflow;
    logic            hs;

    logic [ColW:0]   stepIn;
    logic [ColW-1:0] firstEnd;
    logic [ColW-1:0] nextPtr;
    logic [ColW-1:0] nextEnd;

    assign cmdReady = (state == ESIDLE);
    assign busy     = (state != ESIDLE);
    assign eValid   = (state == ESISSUE) & ~outFull;
    assign done     = (state == ESDRAIN) & outZero;
    assign hs       = eValid & eReady;
    assign eInst    = {opQ, ptr, endQ, mvsyncQ, lastQ};

    assign stepIn   = (cmdColStep == '0) ? (ColW+1)'(1) : {1'b0, cmdColStep};
    assign firstEnd = chunkEnd(cmdColBegin, stepIn, cmdColEnd);
    assign nextPtr  = endQ + ColW'(1);
    assign nextEnd  = chunkEnd(nextPtr, stepQ, colEndQ);

    e_sched_outcnt #(.MaxOut(MaxOut)) uOutCnt (
        .clk       (clk),
        .rst       (rst),
        .inc       (hs),
        .dec       (eFinish),
        .cnt       (outCnt),
        .full      (outFull),
        .zero      (outZero),
        .underflow (underflow)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ESIDLE;
            opQ          <= EOpNop;
            ptr          <= '0;
            endQ         <= '0;
            mvsyncQ      <= 1'b0;
            lastQ        <= 1'b0;
            colBeginQ    <= '0;
            colEndQ      <= '0;
            stepQ        <= '0;
            syncQ        <= 1'b0;
            errCmd       <= 1'b0;
            errUnderflow <= 1'b0;
        end else begin
            if (underflow) errUnderflow <= 1'b1;
            unique case (state)
                ESIDLE: if (cmdValid) begin
                    opQ       <= cmdOpCode;
                    colBeginQ <= cmdColBegin;
                    colEndQ   <= cmdColEnd;
                    stepQ     <= stepIn;
                    syncQ     <= cmdSync;
                    if (cmdColBegin > cmdColEnd) begin
                        errCmd <= 1'b1;
                        state  <= ESDRAIN;
                    end else begin
                        state   <= ESISSUE;
                        ptr     <= cmdColBegin;
                        endQ    <= firstEnd;
                        mvsyncQ <= cmdSync;
                        lastQ   <= (firstEnd == cmdColEnd);
                    end
                end
                ESISSUE: if (hs) begin
                    if (lastQ) begin
                        state <= ESDRAIN;
                    end else begin
                        ptr     <= nextPtr;
                        endQ    <= nextEnd;
                        mvsyncQ <= syncQ & (nextPtr == colBeginQ);
                        lastQ   <= (nextEnd == colEndQ);
                    end
                end
                ESDRAIN: if (outZero) state <= ESIDLE;
                default: state <= ESIDLE;
            endcase
        end
    end

`ifdef ESCHED_PERF_EN
    logic [31:0] busyCyc;
    logic [31:0] stallCyc;
    logic        stall;

    assign stall = (eValid & ~eReady) | ((state == ESISSUE) & outFull);

    always_ff @(posedge clk) begin
        if (rst) begin
            busyCyc  <= '0;
            stallCyc <= '0;
        end else begin
            if (busy && busyCyc != '1) busyCyc <= busyCyc + 32'd1;
            if (stall && stallCyc != '1) stallCyc <= stallCyc + 32'd1;
        end
    end

    assign perfBusyCyc  = busyCyc;
    assign perfStallCyc = stallCyc;
`else
    assign perfBusyCyc  = '0;
    assign perfStallCyc = '0;
`endif

endmodule

// File: tb/tb_e_inst_sched.sv
// Scoreboard bench for e_inst_sched: directed commands, monitor pops expected chunks.
module tb_e_inst_sched;
    import e_inst_sched_pkg::*;

    localparam int ColW = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic cmdValid = 1'b0;
    logic cmdReady;
    EOpCode cmdOpCode = EOpNop;
    logic [ColW-1:0] cmdColBegin = '0;
    logic [ColW-1:0] cmdColEnd = '0;
    logic [ColW-1:0] cmdColStep = '0;
    logic cmdSync = 1'b0;
    logic eValid;
    logic eReady = 1'b0;
    logic [$bits(EInst)-1:0] eInst;
    logic eFinish;
    logic busy;
    logic done;
    logic errCmd;
    logic errUnderflow;
    logic [31:0] perfBusyCyc;
    logic [31:0] perfStallCyc;

    e_inst_sched #(.VColLoop(16), .MaxOut(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .cmdValid     (cmdValid),
        .cmdReady     (cmdReady),
        .cmdOpCode    (cmdOpCode),
        .cmdColBegin  (cmdColBegin),
        .cmdColEnd    (cmdColEnd),
        .cmdColStep   (cmdColStep),
        .cmdSync      (cmdSync),
        .eValid       (eValid),
        .eReady       (eReady),
        .eInst        (eInst),
        .eFinish      (eFinish),
        .busy         (busy),
        .done         (done),
        .errCmd       (errCmd),
        .errUnderflow (errUnderflow),
        .perfBusyCyc  (perfBusyCyc),
        .perfStallCyc (perfStallCyc)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int nVec = 0;
    int nFail = 0;
    EInst expQ[$];
    int hsCnt = 0;
    int hsLast = 0;
    int lastFinCyc = 0;
    int lastDoneCyc = 0;
    int doneCnt = 0;
    int acc = 0;
    logic autoEn = 1'b0;
    logic autoFin = 1'b0;
    logic manFin = 1'b0;
    logic p1 = 1'b0;
    logic p2 = 1'b0;
    logic nf;
    EInst mon;

    assign eFinish = autoFin | manFin;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        nVec++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endfunction

    function automatic EInst mk(EOpCode op, int b, int e, logic s, logic l);
        EInst r;
        r.eOpCode  = op;
        r.colBegin = ColW'(b);
        r.colEnd   = ColW'(e);
        r.mvsync   = s;
        r.eLast    = l;
        return r;
    endfunction

    // monitor: scoreboard pops, eFinish generator (2 cycles after issue), event log
    always @(negedge clk) begin
        if (rst) begin
            p1 = 1'b0;
            p2 = 1'b0;
            autoFin = 1'b0;
        end else begin
            if (eValid && eReady) begin
                hsCnt++;
                hsLast = cyc;
                chk("eInst expected", 32'(expQ.size() != 0), 32'd1);
                if (expQ.size() != 0) begin
                    mon = expQ.pop_front();
                    chk("eInst", 32'(eInst), 32'(mon));
                end
            end
            nf = autoEn & p2;
            if (nf | manFin) lastFinCyc = cyc;
            if (done) begin
                doneCnt++;
                lastDoneCyc = cyc;
            end
            autoFin = nf;
            p2 = p1;
            p1 = eValid && eReady;
        end
    end

    task automatic smp();
        @(negedge clk);
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic doReset();
        tick();
        rst = 1'b1;
        expQ.delete();
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic sendCmd(EOpCode op, int b, int e, int s, logic sy);
        tick();
        cmdOpCode   = op;
        cmdColBegin = ColW'(b);
        cmdColEnd   = ColW'(e);
        cmdColStep  = ColW'(s);
        cmdSync     = sy;
        cmdValid    = 1'b1;
        smp();
        chk("cmdReady at accept", 32'(cmdReady), 32'd1);
        acc = cyc;
        tick();
        cmdValid = 1'b0;
    endtask

    task automatic waitDone(int budget);
        int s;
        bit seen;
        s = doneCnt;
        seen = 1'b0;
        for (int i = 0; i < budget && !seen; i++) begin
            smp();
            if (doneCnt != s) seen = 1'b1;
        end
        chk("done within budget", 32'(seen), 32'd1);
        if (seen) begin
            chk("cmdReady low at done", 32'(cmdReady), 32'd0);
            smp();
            chk("cmdReady after done", 32'(cmdReady), 32'd1);
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit");
        $fatal(1);
    end

    initial begin
        int h0;
        logic [31:0] pf0;
        logic [$bits(EInst)-1:0] e0;

        // reset state
        smp();
        smp();
        chk("rst cmdReady", 32'(cmdReady), 32'd1);
        chk("rst eValid", 32'(eValid), 32'd0);
        chk("rst busy", 32'(busy), 32'd0);
        chk("rst done", 32'(done), 32'd0);
        chk("rst errCmd", 32'(errCmd), 32'd0);
        chk("rst errUnderflow", 32'(errUnderflow), 32'd0);
        chk("rst eInst", 32'(eInst), 32'd0);
        chk("rst perfBusy", perfBusyCyc, 32'd0);
        chk("rst perfStall", perfStallCyc, 32'd0);
        chk("rst outCnt", 32'(dut.outCnt), 32'd0);
        rst = 1'b0;

        // full range, step 4, sync
        autoEn = 1'b1;
        eReady = 1'b1;
        expQ.push_back(mk(EOpMac, 0, 3, 1'b1, 1'b0));
        expQ.push_back(mk(EOpMac, 4, 7, 1'b0, 1'b0));
        expQ.push_back(mk(EOpMac, 8, 11, 1'b0, 1'b0));
        expQ.push_back(mk(EOpMac, 12, 15, 1'b0, 1'b1));
        h0 = hsCnt;
        sendCmd(EOpMac, 0, 15, 4, 1'b1);
        waitDone(40);
        chk("full hs count", hsCnt - h0, 4);
        chk("full last hs cycle", hsLast - acc, 4);
        chk("full done after finish", lastDoneCyc - lastFinCyc, 1);
        chk("full done cycle", lastDoneCyc - acc, 7);
        chk("full queue drained", expQ.size(), 0);

        // partial range, no sync
        expQ.push_back(mk(EOpLoad, 3, 6, 1'b0, 1'b0));
        expQ.push_back(mk(EOpLoad, 7, 9, 1'b0, 1'b1));
        h0 = hsCnt;
        sendCmd(EOpLoad, 3, 9, 4, 1'b0);
        waitDone(40);
        chk("partial hs count", hsCnt - h0, 2);
        chk("partial done after finish", lastDoneCyc - lastFinCyc, 1);
        chk("partial queue drained", expQ.size(), 0);

        // illegal range then idle underflow
        h0 = hsCnt;
        sendCmd(EOpAct, 10, 5, 4, 1'b0);
        waitDone(10);
        chk("illegal done cycle", lastDoneCyc - acc, 1);
        chk("illegal errCmd", 32'(errCmd), 32'd1);
        chk("illegal no issue", hsCnt - h0, 0);
        chk("illegal no underflow", 32'(errUnderflow), 32'd0);
        tick();
        manFin = 1'b1;
        tick();
        manFin = 1'b0;
        smp();
        chk("underflow flag", 32'(errUnderflow), 32'd1);
        chk("underflow outCnt", 32'(dut.outCnt), 32'd0);
        chk("errCmd sticky", 32'(errCmd), 32'd1);

        // outstanding limit, step 1, no automatic finishes
        doReset();
        autoEn = 1'b0;
        eReady = 1'b1;
        for (int i = 0; i < 8; i++)
            expQ.push_back(mk(EOpStore, i, i, 1'b0, i == 7));
        h0 = hsCnt;
        sendCmd(EOpStore, 0, 7, 1, 1'b0);
        repeat (5) smp();
        chk("limit hs count", hsCnt - h0, 4);
        chk("limit eValid low", 32'(eValid), 32'd0);
        chk("limit outCnt", 32'(dut.outCnt), 32'd4);
        tick();
        manFin = 1'b1;
        tick();
        manFin = 1'b0;
        smp();
        chk("limit 5th hs", hsCnt - h0, 5);
        chk("limit 5th hs timing", hsLast - lastFinCyc, 1);
        tick();
        eReady = 1'b0;
        manFin = 1'b1;
        smp();
        chk("limit full again", 32'(eValid), 32'd0);
        tick();
        manFin = 1'b0;
        smp();
        chk("limit after finish eValid", 32'(eValid), 32'd1);
        chk("limit after finish outCnt", 32'(dut.outCnt), 32'd3);
        tick();
        eReady = 1'b1;
        manFin = 1'b1;
        tick();
        manFin = 1'b0;
        smp();
        chk("same-cycle outCnt", 32'(dut.outCnt), 32'd3);
        chk("same-cycle eValid", 32'(eValid), 32'd1);
        chk("same-cycle hs count", hsCnt - h0, 7);
        tick();
        smp();
        chk("limit refill eValid", 32'(eValid), 32'd0);
        chk("limit refill outCnt", 32'(dut.outCnt), 32'd4);
        chk("limit refill hs count", hsCnt - h0, 7);

        // backpressure then reset mid-command
        doReset();
        autoEn = 1'b1;
        eReady = 1'b1;
        for (int i = 0; i < 8; i++)
            expQ.push_back(mk(EOpMac, 2*i, 2*i+1, i == 0, i == 7));
        sendCmd(EOpMac, 0, 15, 2, 1'b1);
        tick();
        eReady = 1'b0;
        smp();
        e0  = eInst;
        pf0 = perfStallCyc;
        chk("stall chunk", 32'(e0), 32'(mk(EOpMac, 2, 3, 1'b0, 1'b0)));
        for (int i = 0; i < 5; i++) begin
            if (i > 0) smp();
            chk("stall eValid", 32'(eValid), 32'd1);
            chk("stall eInst stable", 32'(eInst), 32'(e0));
        end
        tick();
        eReady = 1'b1;
        smp();
`ifdef ESCHED_PERF_EN
        chk("perfStallCyc", perfStallCyc - pf0, 32'd5);
`else
        chk("perfStallCyc tied", perfStallCyc, 32'd0);
`endif
        tick();
        rst = 1'b1;
        autoEn = 1'b0;
        expQ.delete();
        tick();
        rst = 1'b0;
        smp();
        chk("abort eValid", 32'(eValid), 32'd0);
        chk("abort cmdReady", 32'(cmdReady), 32'd1);
        chk("abort busy", 32'(busy), 32'd0);
        chk("abort errCmd", 32'(errCmd), 32'd0);
        chk("abort errUnderflow", 32'(errUnderflow), 32'd0);
        chk("abort outCnt", 32'(dut.outCnt), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nVec, nFail);
        $finish;
    end

endmodule
